// File: rtl/keypad4x4_scan.sv
// 4x4 active-low matrix keypad scanner: row sweep, whole-sweep debounce,
// one-shot key events and a 32-bit hex digit entry shift register.
module keypad4x4_scan #(
  parameter int SCAN_DIV_BITS  = 15,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  i_col,
  input  logic        i_clear,
  output logic [3:0]  o_row,
  output logic [3:0]  o_key,
  output logic        o_key_valid,
  output logic        o_key_down,
  output logic [31:0] o_value
);

  typedef enum logic [1:0] {CL_NONE, CL_SINGLE, CL_MULTI} cls_e;
  typedef struct packed {
    cls_e       cls;
    logic [3:0] code;
  } res_t;
  typedef enum logic {IDLE, HELD} state_e;

  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  logic [3:0]               col_s1_q, col_s2_q;
  logic [SCAN_DIV_BITS-1:0] cnt_q;
  logic [1:0]               r_q;
  logic [2:0][3:0]          samp_q;
  res_t                     cand_q, res;
  logic [3:0]               stable_q, stable_d;
  state_e                   state_q;
  logic [3:0]               key_q;
  logic                     key_valid_q, key_down_q;
  logic [31:0]              value_q;

  logic tick, eos, deb_ok, accept, release_ok;

  assign tick  = &cnt_q;
  assign eos   = tick && (r_q == 2'd3);
  assign o_row = ~(4'b0001 << r_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
      cnt_q    <= '0;
      r_q      <= 2'd0;
      samp_q   <= {3{4'hF}};
    end else begin
      col_s1_q <= i_col;
      col_s2_q <= col_s1_q;
      cnt_q    <= cnt_q + SCAN_DIV_BITS'(1);
      if (tick) begin
        if (r_q != 2'd3) samp_q[r_q] <= col_s2_q;
        r_q <= r_q + 2'd1;
      end
    end
  end

  // Flattened low-bit map: bit index row*4+col is exactly the key code.
  always_comb begin
    logic [15:0] low;
    logic [4:0]  n;
    logic [3:0]  idx;
    low = ~{col_s2_q, samp_q};
    n   = 5'd0;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (low[i]) begin
        n   = n + 5'd1;
        idx = 4'(i);
      end
    end
    res.cls  = CL_NONE;
    res.code = 4'd0;
    if (n == 5'd1) begin
      res.cls  = CL_SINGLE;
      res.code = idx;
    end else if (n > 5'd1) begin
      res.cls  = CL_MULTI;
    end
  end

  always_comb begin
    stable_d = 4'd1;
    if (res == cand_q) stable_d = (stable_q >= DEB) ? DEB : stable_q + 4'd1;
  end

  assign deb_ok     = (stable_d == DEB);
  assign accept     = eos && (state_q == IDLE) && (res.cls == CL_SINGLE) && deb_ok;
  assign release_ok = eos && (state_q == HELD) && (res.cls == CL_NONE) && deb_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cand_q      <= '{cls: CL_NONE, code: 4'd0};
      stable_q    <= 4'd0;
      state_q     <= IDLE;
      key_q       <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      value_q     <= 32'd0;
    end else begin
      key_valid_q <= 1'b0;
      if (eos) begin
        cand_q   <= res;
        stable_q <= stable_d;
      end
      if (accept) begin
        state_q     <= HELD;
        key_q       <= res.code;
        key_valid_q <= 1'b1;
        key_down_q  <= 1'b1;
      end else if (release_ok) begin
        state_q    <= IDLE;
        key_down_q <= 1'b0;
      end
      // Clear has priority over shifting in a freshly accepted digit.
      if (i_clear)     value_q <= 32'd0;
      else if (accept) value_q <= {value_q[27:0], res.code};
    end
  end

  assign o_key       = key_q;
  assign o_key_valid = key_valid_q;
  assign o_key_down  = key_down_q;
  assign o_value     = value_q;

endmodule
